// File: rtl/present_pkg.sv
// Shared definitions for the PRESENT block cipher core: S-box tables,
// round count, FSM encoding and the bit-permutation index rule.
package present_pkg;

    localparam int NUM_ROUNDS = 31;
    localparam int ROUND_W    = 6;

    // Round counter landmarks: last keyed round, and the extra whitening step.
    localparam logic [ROUND_W-1:0] LAST_ROUND = ROUND_W'(NUM_ROUNDS);
    localparam logic [ROUND_W-1:0] FINAL_STEP = ROUND_W'(NUM_ROUNDS + 1);

    // Nibble n of each table lives at bits [4n+3:4n].
    localparam logic [63:0] SBOX_TABLE     = 64'h2174_8FE3_DA09_B65C;
    localparam logic [63:0] INV_SBOX_TABLE = 64'hA970_364B_D21C_8FE5;

    typedef enum logic [2:0] {
        IDLE,
        KEYX,
        ENC,
        DEC,
        OUT
    } fsm_state_t;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        return INV_SBOX_TABLE[{x, 2'b00} +: 4];
    endfunction

    // pLayer destination of source bit i: i*16 mod 63, with bit 63 fixed.
    function automatic int p_index(input int i);
        return (i == 63) ? 63 : (i * 16) % 63;
    endfunction

endpackage

// File: rtl/present_cipher_core_if.sv
// Request/response bundle of the PRESENT core.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both 1. The request side (in_*) is only sampled while in_ready is 1; the
// response side holds out_valid and out_data stable until out_ready is seen.
interface present_cipher_core_if #(
    parameter int KEY_W = 80
) ();
    logic             in_valid;
    logic             in_ready;
    logic             in_dec;
    logic [63:0]      in_data;
    logic [KEY_W-1:0] in_key;
    logic             out_valid;
    logic             out_ready;
    logic [63:0]      out_data;

    modport master (
        output in_valid, in_dec, in_data, in_key, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_dec, in_data, in_key, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/present_round_unit.sv
// Combinational PRESENT round logic: one forward round, one inverse round,
// and the forward/inverse key-schedule step for an 80- or 128-bit key.
module present_round_unit
    import present_pkg::*;
#(
    parameter int KEY_W = 80
) (
    input  logic [63:0]      state,
    input  logic [KEY_W-1:0] key,
    input  logic [4:0]       rc,
    output logic [63:0]      fwd_state,
    output logic [63:0]      inv_state,
    output logic [KEY_W-1:0] key_next,
    output logic [KEY_W-1:0] key_prev
);

    localparam int ROT = 61;

    logic [63:0]      fwd_mix;
    logic [63:0]      fwd_sub;
    logic [63:0]      inv_perm;
    logic [63:0]      inv_sub;
    logic [KEY_W-1:0] key_rot;
    logic [KEY_W-1:0] key_unmix;

    assign fwd_mix = state ^ key[KEY_W-1 -: 64];

    // Forward substitution layer over all sixteen nibbles.
    always_comb begin
        fwd_sub = '0;
        for (int n = 0; n < 16; n++) begin
            fwd_sub[4*n +: 4] = sbox(fwd_mix[4*n +: 4]);
        end
    end

    // Bit permutation is pure wiring in both directions.
    for (genvar g = 0; g < 64; g++) begin : g_perm
        assign fwd_state[p_index(g)] = fwd_sub[g];
        assign inv_perm[g]           = state[p_index(g)];
    end

    // Inverse substitution layer applied after undoing the permutation.
    always_comb begin
        inv_sub = '0;
        for (int n = 0; n < 16; n++) begin
            inv_sub[4*n +: 4] = inv_sbox(inv_perm[4*n +: 4]);
        end
    end

    // The inverse round adds the key of the round being undone.
    assign inv_state = inv_sub ^ key_prev[KEY_W-1 -: 64];

    assign key_rot  = {key[KEY_W-ROT-1:0], key[KEY_W-1:KEY_W-ROT]};
    assign key_prev = {key_unmix[ROT-1:0], key_unmix[KEY_W-1:ROT]};

    if (KEY_W == 128) begin : g_key128
        // Forward key step: two S-boxes on the top byte, counter at [66:62].
        always_comb begin
            key_next            = key_rot;
            key_next[127:124]   = sbox(key_rot[127:124]);
            key_next[123:120]   = sbox(key_rot[123:120]);
            key_next[66:62]     = key_rot[66:62] ^ rc;
        end
        // Undo counter and S-boxes; the right rotation is applied outside.
        always_comb begin
            key_unmix           = key;
            key_unmix[66:62]    = key[66:62] ^ rc;
            key_unmix[127:124]  = inv_sbox(key[127:124]);
            key_unmix[123:120]  = inv_sbox(key[123:120]);
        end
    end else begin : g_key80
        // Forward key step: one S-box on the top nibble, counter at [19:15].
        always_comb begin
            key_next            = key_rot;
            key_next[79:76]     = sbox(key_rot[79:76]);
            key_next[19:15]     = key_rot[19:15] ^ rc;
        end
        // Undo counter and S-box; the right rotation is applied outside.
        always_comb begin
            key_unmix           = key;
            key_unmix[19:15]    = key[19:15] ^ rc;
            key_unmix[79:76]    = inv_sbox(key[79:76]);
        end
    end

endmodule

// File: rtl/present_cipher_core.sv
// Iterative PRESENT cipher core, one round per clock. Encryption runs the
// rounds directly; decryption first walks the key schedule forward to the
// last round key, then unwinds rounds while stepping the key backwards.
module present_cipher_core
    import present_pkg::*;
#(
    parameter int KEY_W = 80
) (
    input  logic                 clk,
    input  logic                 rst,
    present_cipher_core_if.slave bus,
    output fsm_state_t           dbg_state,
    output logic [ROUND_W-1:0]   dbg_round
);

    localparam logic [ROUND_W-1:0] ROUND_STEP = ROUND_W'(1);

    fsm_state_t         fsm_q;
    fsm_state_t         fsm_d;
    logic [63:0]        data_q;
    logic [63:0]        data_d;
    logic [KEY_W-1:0]   key_q;
    logic [KEY_W-1:0]   key_d;
    logic [ROUND_W-1:0] round_q;
    logic [ROUND_W-1:0] round_d;
    logic [63:0]        out_q;
    logic [63:0]        out_d;

    logic [63:0]        fwd_state;
    logic [63:0]        inv_state;
    logic [KEY_W-1:0]   key_next;
    logic [KEY_W-1:0]   key_prev;

    present_round_unit #(
        .KEY_W(KEY_W)
    ) u_round (
        .state     (data_q),
        .key       (key_q),
        .rc        (round_q[4:0]),
        .fwd_state (fwd_state),
        .inv_state (inv_state),
        .key_next  (key_next),
        .key_prev  (key_prev)
    );

    assign bus.in_ready  = (fsm_q == IDLE);
    assign bus.out_valid = (fsm_q == OUT);
    assign bus.out_data  = out_q;
    assign dbg_state     = fsm_q;
    assign dbg_round     = round_q;

    // Next-state and datapath update for every FSM state.
    always_comb begin
        fsm_d   = fsm_q;
        data_d  = data_q;
        key_d   = key_q;
        round_d = round_q;
        out_d   = out_q;
        case (fsm_q)
            IDLE: begin
                round_d = '0;
                if (bus.in_valid) begin
                    data_d  = bus.in_data;
                    key_d   = bus.in_key;
                    round_d = ROUND_STEP;
                    fsm_d   = bus.in_dec ? KEYX : ENC;
                end
            end
            ENC: begin
                if (round_q == FINAL_STEP) begin
                    // Output whitening with the 32nd round key.
                    out_d   = data_q ^ key_q[KEY_W-1 -: 64];
                    round_d = '0;
                    fsm_d   = OUT;
                end else begin
                    data_d  = fwd_state;
                    key_d   = key_next;
                    round_d = round_q + ROUND_STEP;
                end
            end
            KEYX: begin
                // Data is left alone while the key advances to K32.
                key_d   = key_next;
                round_d = round_q + ROUND_STEP;
                if (round_q == LAST_ROUND) begin
                    fsm_d = DEC;
                end
            end
            DEC: begin
                if (round_q == FINAL_STEP) begin
                    // Strip the output whitening before unwinding rounds.
                    data_d  = data_q ^ key_q[KEY_W-1 -: 64];
                    round_d = LAST_ROUND;
                end else begin
                    key_d   = key_prev;
                    data_d  = inv_state;
                    round_d = round_q - ROUND_STEP;
                    if (round_q == ROUND_STEP) begin
                        out_d = inv_state;
                        fsm_d = OUT;
                    end
                end
            end
            OUT: begin
                round_d = '0;
                if (bus.out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d   = IDLE;
                round_d = '0;
            end
        endcase
    end

    // All architectural state, with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            data_q  <= '0;
            key_q   <= '0;
            round_q <= '0;
            out_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            data_q  <= data_d;
            key_q   <= key_d;
            round_q <= round_d;
            out_q   <= out_d;
        end
    end

endmodule

// File: tb/tb_present_cipher_core.sv
// Bench for present_cipher_core: an 80-bit and a 128-bit instance, a
// textbook PRESENT model, a cycle-level expectation tracker and a per-cycle
// compare process, plus directed known-answer and abort scenarios.
`timescale 1ns/1ps
module tb_present_cipher_core;
    import present_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- DUTs ----------------
    present_cipher_core_if #(.KEY_W(80))  bus80 ();
    present_cipher_core_if #(.KEY_W(128)) bus128 ();
    fsm_state_t dbg_state80;
    fsm_state_t dbg_state128;
    logic [5:0] dbg_round80;
    logic [5:0] dbg_round128;

    present_cipher_core #(.KEY_W(80)) dut80 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus80),
        .dbg_state (dbg_state80),
        .dbg_round (dbg_round80)
    );

    present_cipher_core #(.KEY_W(128)) dut128 (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus128),
        .dbg_state (dbg_state128),
        .dbg_round (dbg_round128)
    );

    // Driver-side values per instance (0 = 80-bit, 1 = 128-bit).
    logic         drv_valid [2];
    logic         drv_dec   [2];
    logic [63:0]  drv_data  [2];
    logic [127:0] drv_key   [2];
    logic         drv_ready [2];

    assign bus80.in_valid   = drv_valid[0];
    assign bus80.in_dec     = drv_dec[0];
    assign bus80.in_data    = drv_data[0];
    assign bus80.in_key     = drv_key[0][79:0];
    assign bus80.out_ready  = drv_ready[0];
    assign bus128.in_valid  = drv_valid[1];
    assign bus128.in_dec    = drv_dec[1];
    assign bus128.in_data   = drv_data[1];
    assign bus128.in_key    = drv_key[1];
    assign bus128.out_ready = drv_ready[1];

    logic        v_in_ready  [2];
    logic        v_out_valid [2];
    logic [63:0] v_out_data  [2];
    fsm_state_t  v_state     [2];
    logic [5:0]  v_round     [2];

    assign v_in_ready[0]  = bus80.in_ready;
    assign v_out_valid[0] = bus80.out_valid;
    assign v_out_data[0]  = bus80.out_data;
    assign v_state[0]     = dbg_state80;
    assign v_round[0]     = dbg_round80;
    assign v_in_ready[1]  = bus128.in_ready;
    assign v_out_valid[1] = bus128.out_valid;
    assign v_out_data[1]  = bus128.out_data;
    assign v_state[1]     = dbg_state128;
    assign v_round[1]     = dbg_round128;

    // ---------------- reference cipher ----------------
    logic [3:0] sb [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                            4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    logic [3:0] sbi [16];

    function automatic logic [63:0] f_sub(input logic [63:0] s, input bit inv);
        logic [63:0] o;
        for (int n = 0; n < 16; n++) o[4*n +: 4] = inv ? sbi[s[4*n +: 4]] : sb[s[4*n +: 4]];
        return o;
    endfunction

    function automatic logic [63:0] f_perm(input logic [63:0] s, input bit inv);
        logic [63:0] o;
        int p;
        for (int i = 0; i < 64; i++) begin
            p = (i == 63) ? 63 : (i * 16) % 63;
            if (inv) o[i] = s[p];
            else     o[p] = s[i];
        end
        return o;
    endfunction

    function automatic logic [127:0] f_kupd(input logic [127:0] k, input int kw, input int rc);
        logic [127:0] o;
        int base;
        o = '0;
        for (int j = 0; j < kw; j++) o[(j + 61) % kw] = k[j];
        o[kw-1 -: 4] = sb[o[kw-1 -: 4]];
        if (kw == 128) o[kw-5 -: 4] = sb[o[kw-5 -: 4]];
        base = (kw == 80) ? 15 : 62;
        for (int b = 0; b < 5; b++) o[base+b] = o[base+b] ^ rc[b];
        return o;
    endfunction

    function automatic logic [63:0] f_top(input logic [127:0] k, input int kw);
        return k[kw-1 -: 64];
    endfunction

    function automatic logic [63:0] f_encrypt(input logic [63:0] pt, input logic [127:0] key, input int kw);
        logic [63:0]  s;
        logic [127:0] k;
        s = pt;
        k = key;
        for (int r = 1; r <= 31; r++) begin
            s = f_perm(f_sub(s ^ f_top(k, kw), 1'b0), 1'b0);
            k = f_kupd(k, kw, r);
        end
        return s ^ f_top(k, kw);
    endfunction

    function automatic logic [63:0] f_decrypt(input logic [63:0] ct, input logic [127:0] key, input int kw);
        logic [63:0]  rk [33];
        logic [63:0]  s;
        logic [127:0] k;
        k = key;
        for (int r = 1; r <= 32; r++) begin
            rk[r] = f_top(k, kw);
            if (r < 32) k = f_kupd(k, kw, r);
        end
        s = ct ^ rk[32];
        for (int r = 31; r >= 1; r--) s = f_sub(f_perm(s, 1'b1), 1'b1) ^ rk[r];
        return s;
    endfunction

    // ---------------- scoreboard / cycle expectation ----------------
    logic [63:0] exp_q0 [$];
    logic [63:0] exp_q1 [$];
    bit          m_busy [2] = '{1'b0, 1'b0};
    bit          m_outv [2] = '{1'b0, 1'b0};
    int          m_cnt  [2] = '{0, 0};
    logic [63:0] m_outd [2] = '{64'h0, 64'h0};
    bit          chk_en = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input int d);
        logic [127:0] k;
        logic [63:0]  r;
        int kw;
        kw = (d == 0) ? 80 : 128;
        if (rst) begin
            m_busy[d] = 1'b0;
            m_outv[d] = 1'b0;
            m_outd[d] = '0;
            if (d == 0) exp_q0.delete();
            else        exp_q1.delete();
        end else if (m_outv[d]) begin
            if (drv_ready[d]) m_outv[d] = 1'b0;
        end else if (m_busy[d]) begin
            m_cnt[d]--;
            if (m_cnt[d] == 0) begin
                m_busy[d] = 1'b0;
                m_outv[d] = 1'b1;
                m_outd[d] = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            end
        end else if (drv_valid[d]) begin
            k = drv_key[d];
            if (d == 0) k = {48'h0, k[79:0]};
            r = drv_dec[d] ? f_decrypt(drv_data[d], k, kw) : f_encrypt(drv_data[d], k, kw);
            if (d == 0) exp_q0.push_back(r);
            else        exp_q1.push_back(r);
            m_busy[d] = 1'b1;
            m_cnt[d]  = drv_dec[d] ? 63 : 32;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    // Compare DUT outputs against the expectation on every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check($sformatf("in_ready[%0d]", d), v_in_ready[d], !m_busy[d] && !m_outv[d]);
                check($sformatf("out_valid[%0d]", d), v_out_valid[d], m_outv[d]);
                check($sformatf("out_data[%0d]", d), v_out_data[d], m_outd[d]);
                if (m_busy[d]) begin
                    check($sformatf("round_range[%0d]", d), (v_round[d] >= 6'd1) && (v_round[d] <= 6'd32), 1'b1);
                end else begin
                    check($sformatf("round_zero[%0d]", d), v_round[d], 6'd0);
                    check($sformatf("state[%0d]", d), v_state[d], m_outv[d] ? OUT : IDLE);
                end
            end
        end
    end

    // ---------------- driver ----------------
    task automatic do_op(input int d, input bit dec, input logic [63:0] data, input logic [127:0] key,
                         input int hold, input bit poke, output logic [63:0] res, output int lat);
        int n;
        n = 0;
        while (!v_in_ready[d] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("in_ready_wait", v_in_ready[d], 1'b1);
        drv_valid[d] = 1'b1;
        drv_dec[d]   = dec;
        drv_data[d]  = data;
        drv_key[d]   = key;
        drv_ready[d] = 1'b0;
        @(negedge clk);
        lat = 0;
        while (!v_out_valid[d] && lat < 200) begin
            drv_valid[d] = 1'($urandom_range(0, 1));
            drv_dec[d]   = 1'($urandom_range(0, 1));
            drv_data[d]  = {$urandom, $urandom};
            drv_key[d]   = {$urandom, $urandom, $urandom, $urandom};
            drv_ready[d] = 1'($urandom_range(0, 1));
            @(negedge clk);
            lat++;
        end
        drv_valid[d] = 1'b0;
        drv_ready[d] = 1'b0;
        res = v_out_data[d];
        for (int i = 0; i < hold; i++) begin
            if (poke) begin
                drv_valid[d] = 1'b1;
                drv_dec[d]   = 1'($urandom_range(0, 1));
                drv_data[d]  = {$urandom, $urandom};
                drv_key[d]   = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            check("hold_valid", v_out_valid[d], 1'b1);
            check("hold_data", v_out_data[d], res);
            check("hold_in_ready", v_in_ready[d], 1'b0);
        end
        drv_valid[d] = 1'b0;
        drv_ready[d] = 1'b1;
        @(negedge clk);
        drv_ready[d] = 1'b0;
        check("after_handshake_valid", v_out_valid[d], 1'b0);
        check("after_handshake_data", v_out_data[d], res);
    endtask

    // ---------------- main sequence ----------------
    logic [63:0]  res;
    logic [63:0]  ct;
    logic [63:0]  pt;
    logic [127:0] key;
    int           lat;
    bit           dec;

    initial begin
        for (int d = 0; d < 2; d++) begin
            drv_valid[d] = 1'b0;
            drv_dec[d]   = 1'b0;
            drv_data[d]  = '0;
            drv_key[d]   = '0;
            drv_ready[d] = 1'b0;
        end
        for (int x = 0; x < 16; x++) sbi[sb[x]] = 4'(x);

        // Pin the reference model to published test vectors.
        check("model_enc80_zero", f_encrypt(64'h0, 128'h0, 80), 64'h5579C1387B228445);
        check("model_enc80_ones", f_encrypt({64{1'b1}}, {48'h0, {80{1'b1}}}, 80), 64'h3333DCD3213210D2);
        check("model_enc128_zero", f_encrypt(64'h0, 128'h0, 128), 64'h96DB702A2E6900AF);

        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        for (int d = 0; d < 2; d++) begin
            check("reset_in_ready", v_in_ready[d], 1'b1);
            check("reset_out_valid", v_out_valid[d], 1'b0);
            check("reset_out_data", v_out_data[d], 64'h0);
            check("reset_round", v_round[d], 6'd0);
            check("reset_state", v_state[d], IDLE);
        end

        // Known answers, 80-bit key.
        do_op(0, 1'b0, 64'h0, 128'h0, 2, 1'b0, res, lat);
        check("enc80_zero", res, 64'h5579C1387B228445);
        check("enc80_zero_latency", lat, 32);
        do_op(0, 1'b0, {64{1'b1}}, {48'h0, {80{1'b1}}}, 0, 1'b0, res, lat);
        check("enc80_ones", res, 64'h3333DCD3213210D2);
        check("enc80_ones_latency", lat, 32);
        do_op(0, 1'b1, 64'h3333DCD3213210D2, {48'h0, {80{1'b1}}}, 1, 1'b0, res, lat);
        check("dec80_ones", res, {64{1'b1}});
        check("dec80_ones_latency", lat, 63);

        // Known answer and random round trips, 128-bit key.
        do_op(1, 1'b0, 64'h0, 128'h0, 0, 1'b0, res, lat);
        check("enc128_zero", res, 64'h96DB702A2E6900AF);
        check("enc128_zero_latency", lat, 32);
        for (int i = 0; i < 100; i++) begin
            pt  = {$urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            do_op(1, 1'b0, pt, key, $urandom_range(0, 3), 1'b0, ct, lat);
            check("rt128_enc", ct, f_encrypt(pt, key, 128));
            check("rt128_enc_latency", lat, 32);
            do_op(1, 1'b1, ct, key, $urandom_range(0, 3), 1'b0, res, lat);
            check("rt128_dec", res, pt);
            check("rt128_dec_latency", lat, 63);
        end

        // Mixed random operations, 80-bit key.
        for (int i = 0; i < 20; i++) begin
            pt  = {$urandom, $urandom};
            key = {48'h0, $urandom, $urandom, 16'($urandom)};
            dec = 1'($urandom_range(0, 1));
            do_op(0, dec, pt, key, $urandom_range(0, 2), 1'b0, res, lat);
            check("mix80_data", res, dec ? f_decrypt(pt, key, 80) : f_encrypt(pt, key, 80));
            check("mix80_latency", lat, dec ? 63 : 32);
        end

        // Back-pressure in OUT with ignored requests.
        pt  = {$urandom, $urandom};
        key = {48'h0, $urandom, $urandom, 16'($urandom)};
        do_op(0, 1'b0, pt, key, 10, 1'b1, res, lat);
        check("stall80_data", res, f_encrypt(pt, key, 80));

        // Reset during decryption aborts the result.
        drv_valid[0] = 1'b1;
        drv_dec[0]   = 1'b1;
        drv_data[0]  = {$urandom, $urandom};
        drv_key[0]   = {$urandom, $urandom, $urandom, $urandom};
        check("abort_accept_ready", v_in_ready[0], 1'b1);
        @(negedge clk);
        drv_valid[0] = 1'b0;
        lat = 0;
        while (lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("abort_in_dec", v_state[0], DEC);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_in_ready", v_in_ready[0], 1'b1);
        check("abort_out_valid", v_out_valid[0], 1'b0);
        check("abort_out_data", v_out_data[0], 64'h0);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            check("abort_no_valid", v_out_valid[0], 1'b0);
        end
        do_op(0, 1'b0, 64'h0, 128'h0, 0, 1'b0, res, lat);
        check("post_abort_enc80_zero", res, 64'h5579C1387B228445);
        check("post_abort_latency", lat, 32);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/present_cipher_core.md
PRESENT_CIPHER_CORE -- requirements
Module: present_cipher_core

Interface
REQ-001 SHALL have parameter KEY_W, default 80, key length in bits; legal values 80 and 128 only.
REQ-002 SHALL have clk  input  1  rising-edge clock.
REQ-003 SHALL have rst  input  1  reset: synchronous, active-high.
REQ-004 SHALL have in_valid  input  1  request valid.
REQ-005 SHALL have in_ready  output  1  core can accept a request.
REQ-006 SHALL have in_dec  input  1  mode: 0 = encrypt, 1 = decrypt.
REQ-007 SHALL have in_data  input  64  plaintext (encrypt) or ciphertext (decrypt).
REQ-008 SHALL have in_key  input  KEY_W  cipher key.
REQ-009 SHALL have out_valid  output  1  result valid.
REQ-010 SHALL have out_ready  input  1  consumer accepts result.
REQ-011 SHALL have out_data  output  64  result block.

Function
REQ-012 SHALL implement the FSM states IDLE, KEYX, ENC, DEC and OUT; in_ready SHALL be 1 only in IDLE.
REQ-013 SHALL accept a request on an edge where in_valid && in_ready, capturing in_data, in_key and in_dec; after acceptance, in_valid and the input buses SHALL be don't-care.
REQ-014 SHALL, on accepting an encrypt request: go IDLE->ENC with round=1.
- ENC, rounds 1..31, one per cycle: state <= pLayer(S(state ^ K[KEY_W-1:KEY_W-64])); K <= ksched(K, round).
- Next cycle: out_data <= state ^ K top 64; go to OUT.
- out_valid SHALL rise 32 edges after the accept edge.
REQ-015 SHALL implement ksched as: rotate left by 61.
- KEY_W=80: S-box on [79:76]; XOR round[4:0] into [19:15].
- KEY_W=128: S-box on [127:124] and [123:120]; XOR round[4:0] into [66:62].
REQ-016 SHALL, on accepting a decrypt request: go IDLE->KEYX and run ksched for rounds 1..31 (31 cycles) to reach K32, with the data register untouched.
- Then DEC, first cycle: state <= state ^ K32 top 64.
- Then DEC, 31 cycles, i = 31 down to 1: K <= inverse ksched(K, i); state <= invS(invP(state)) ^ (new K top 64).
- Then go to OUT.
- out_valid SHALL rise 63 edges after the accept edge.
REQ-017 SHALL, in OUT, hold out_valid=1 and out_data stable until out_valid && out_ready, then return to IDLE on that edge; in_ready SHALL go to 1 the following cycle; there is no same-edge re-accept.
REQ-018 SHALL ignore in_valid in every state other than IDLE; no queuing and no error flag.
REQ-019 SHALL use a round counter of 6 bits; it SHALL never wrap during an operation and SHALL be 0 in IDLE and OUT.
REQ-020 SHALL keep out_data at its last value after the OUT handshake until the next result is written.

Reset
REQ-021 SHALL, when rst=1 at an edge, set: FSM=IDLE, in_ready=1 from the next cycle, out_valid=0, out_data=0, state=0, K=0, round=0.
REQ-022 SHALL, on rst during KEYX/ENC/DEC/OUT, abort the operation, discard the pending result, and produce no out_valid pulse.
REQ-023 SHALL give rst priority over in_valid and out_ready on the same edge.

Structure
REQ-024 SHALL place in package present_pkg: the S-box and inverse S-box tables, NUM_ROUNDS=31, the FSM state enum, and the pLayer/invP index rule (i*16 mod 63; bit 63 fixed).
REQ-025 SHALL have one sub-module present_round_unit: combinational forward/inverse round plus forward/inverse key step, parametrised by KEY_W.
REQ-026 SHALL have all state registers in the top level only.

Verification
REQ-027 SHALL cover: KEY_W=80, encrypt pt=0, key=0 -> out_data=5579C1387B228445 with out_valid 32 edges after accept.
REQ-028 SHALL cover: KEY_W=80, encrypt pt=FFFFFFFFFFFFFFFF, key=all-ones -> 3333DCD3213210D2; then decrypt of that value with the same key -> FFFFFFFFFFFFFFFF after 63 edges.
REQ-029 SHALL cover: KEY_W=128, encrypt pt=0, key=0 -> 96DB702A2E6900AF, plus a decrypt round-trip for 100 random pt/key pairs.
REQ-030 SHALL cover: out_ready held 0 for 10 cycles in OUT -> out_valid and out_data stable, in_ready=0, and a second in_valid is ignored.
REQ-031 SHALL cover: rst asserted at DEC cycle 20 -> out_valid never rises, in_ready=1 the next cycle, and the next encrypt (pt=0, key=0) returns 5579C1387B228445.
